// File: rtl/mem_port_arbiter.sv
// Two-way arbiter sharing one single-port memory between instruction fetch and load/store.
// Data wins by default; fetch is forced after STARVE_LIMIT data grants while it waits.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    input  logic              d_wen,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_wen,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              state_reg, state_next;
    logic [3:0]          streak_reg, streak_next;
    logic                mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]         mem_wdata_reg, mem_wdata_next;
    logic [3:0]          mem_wmask_reg, mem_wmask_next;
    logic                mem_wen_reg, mem_wen_next;
    logic                grant_d, grant_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
            mem_wen_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wmask_reg <= mem_wmask_next;
            mem_wen_reg   <= mem_wen_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        mem_req_next   = mem_req_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wmask_next = mem_wmask_reg;
        mem_wen_next   = mem_wen_reg;

        // Fetch only wins a contested slot once the streak has reached the limit.
        grant_d = d_req && (!if_req || (streak_reg < LIMIT));
        grant_i = if_req && !grant_d;

        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next     = BUSY_D;
                    mem_req_next   = 1'b1;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                    mem_wmask_next = d_wmask;
                    mem_wen_next   = d_wen;
                    if (if_req)
                        streak_next = (streak_reg >= LIMIT) ? LIMIT : streak_reg + 4'd1;
                    else
                        streak_next = '0;
                end else if (grant_i) begin
                    state_next     = BUSY_I;
                    mem_req_next   = 1'b1;
                    mem_addr_next  = if_addr;
                    mem_wmask_next = '0;
                    mem_wen_next   = 1'b0;
                    streak_next    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    assign if_valid  = (state_reg == BUSY_I) && mem_ready;
    assign d_valid   = (state_reg == BUSY_D) && mem_ready;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign mem_wen   = mem_wen_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset, if_req, d_req, d_wen, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wmask;
    logic        if_valid, d_valid, mem_req, mem_wen;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wen(d_wen),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wen(mem_wen), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: the transaction currently (or most recently) on the memory port.
    typedef struct packed {
        logic        active;
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
    } txn_t;

    txn_t  cur;
    int    streak;          // data grants made while a fetch sat waiting
    string olog;            // completion order as seen on the DUT's valid pulses

    int          mem_mode;  // 0 random ready, 1 fixed latency, 2 ready stuck high
    int          mem_lat;
    int          busy_cnt;
    logic [31:0] rdata_val;
    bit          rand_mode, i_renew, d_renew, saw_i, saw_d;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string exp);
        n_cmp++;
        assert (olog == exp) else begin
            n_mis++;
            $error("FAIL %s observed=%s expected=%s", tag, olog, exp);
        end
    endtask

    task automatic new_d();
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wmask = 4'($urandom_range(0, 15));
        d_wen   = ($urandom_range(0, 1) == 1);
    endtask

    // One clock cycle: drive memory side, compare, advance model, react as requesters.
    task automatic tick();
        case (mem_mode)
            0:       mem_ready = ($urandom_range(0, 2) == 0);
            1:       mem_ready = mem_req && (busy_cnt >= mem_lat);
            default: mem_ready = 1'b1;
        endcase
        mem_rdata = rand_mode ? $urandom : rdata_val;
        #1;
        chk1("mem_req", mem_req, cur.active);
        chk32("mem_addr", mem_addr, cur.addr);
        chk32("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
        chk1("mem_wen", mem_wen, cur.wen);
        if (cur.active && cur.is_data) chk32("mem_wdata", mem_wdata, cur.wdata);
        chk1("if_valid", if_valid, cur.active && !cur.is_data && mem_ready);
        chk1("d_valid", d_valid, cur.active && cur.is_data && mem_ready);
        chk32("if_rdata", if_rdata, mem_rdata);
        chk32("d_rdata", d_rdata, mem_rdata);
        saw_i = (if_valid === 1'b1);
        saw_d = (d_valid === 1'b1);
        if (saw_i) olog = {olog, "I"};
        if (saw_d) olog = {olog, "D"};

        if (reset) begin
            cur    = '0;
            streak = 0;
        end else if (cur.active) begin
            if (mem_ready) cur.active = 1'b0;
        end else if (d_req && !(if_req && streak >= LIMIT)) begin
            cur    = '{1'b1, 1'b1, d_addr, d_wdata, d_wmask, d_wen};
            streak = if_req ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
        end else if (if_req) begin
            cur    = '{1'b1, 1'b0, if_addr, cur.wdata, 4'h0, 1'b0};
            streak = 0;
        end
        busy_cnt = mem_req ? busy_cnt + 1 : 0;

        @(posedge clk);
        @(negedge clk);
        if (rand_mode) begin
            i_renew = ($urandom_range(0, 1) == 1);
            d_renew = ($urandom_range(0, 1) == 1);
        end
        if (saw_i) begin if_req = i_renew; if_addr = $urandom & 32'hFFFF_FFFC; end
        if (saw_d) begin d_req = d_renew; new_d(); end
        if (rand_mode) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; new_d();
            end
            reset = ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = '0;
        d_addr = '0; d_wdata = '0; d_wmask = '0; d_wen = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        cur = '0; streak = 0; olog = ""; busy_cnt = 0;
        mem_mode = 1; mem_lat = 0; rdata_val = 32'h0; rand_mode = 1'b0;
        i_renew = 1'b0; d_renew = 1'b0; saw_i = 1'b0; saw_d = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        ticks(2);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        // Lone fetch, memory answers one cycle after mem_req
        olog = ""; mem_lat = 1; rdata_val = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk1("fetch_req", mem_req, 1'b1);
        chk32("fetch_addr", mem_addr, 32'h100);
        chk1("fetch_wen", mem_wen, 1'b0);
        ticks(3);
        chk_str("fetch_order", "I");

        // Store held through three wait cycles
        olog = ""; mem_lat = 3;
        d_req = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'h3; d_wen = 1'b1;
        tick();
        ticks(3);
        chk32("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk32("store_wmask", 32'(mem_wmask), 32'h3);
        chk1("store_wen", mem_wen, 1'b1);
        ticks(2);
        chk_str("store_order", "D");

        // Simultaneous requests: data first, fetch in the next bubble
        olog = ""; mem_lat = 0;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; new_d();
        ticks(5);
        chk_str("simul_order", "DI");

        // Starvation limit with both sides continually re-requesting
        olog = ""; i_renew = 1'b1; d_renew = 1'b1;
        if_req = 1'b1; d_req = 1'b1; new_d();
        ticks(12);
        chk_str("starve_order", "DDDDID");
        if_req = 1'b0; d_req = 1'b0; i_renew = 1'b0; d_renew = 1'b0;
        ticks(2);

        // Reset while a load/store waits on memory
        olog = ""; mem_lat = 2;
        d_req = 1'b1; new_d();
        ticks(2);
        reset = 1'b1;
        tick();
        chk1("abort_mem_req", mem_req, 1'b0);
        reset = 1'b0;
        ticks(5);
        chk_str("abort_order", "D");

        // Stray ready with no requests
        olog = ""; mem_mode = 2;
        ticks(3);
        chk1("stray_mem_req", mem_req, 1'b0);
        chk_str("stray_order", "");

        // Randomized traffic, ready pattern and occasional reset
        mem_mode = 0; rand_mode = 1'b1;
        ticks(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
